// File: rtl/cpu_trap_unit_pkg.sv
// cpu_trap_unit_pkg
//   Shared constants for the machine-mode trap sequencer: exception cause
//   codes from the exception logic, privilege encodings, CSR addresses,
//   mstatus bit positions, mcause values and the sequencer state type.
package cpu_trap_unit_pkg;

  // Exception verdict codes delivered with each committing instruction
  localparam logic [1:0] EXCAUSE_ECALL         = 2'd0;
  localparam logic [1:0] EXCAUSE_EBREAK        = 2'd1;
  localparam logic [1:0] EXCAUSE_ILLEGAL_INSTR = 2'd2;
  localparam logic [1:0] EXCAUSE_MISALIGNED    = 2'd3;

  // Privilege levels
  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  // CSR addresses held by this block
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;

  // mstatus field positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // mcause values (synchronous exceptions only)
  localparam logic [3:0] MCAUSE_ILLEGAL_INSTR = 4'd2;
  localparam logic [3:0] MCAUSE_BREAKPOINT    = 4'd3;
  localparam logic [3:0] MCAUSE_MISALIGNED    = 4'd4;
  localparam logic [3:0] MCAUSE_ECALL_BASE    = 4'd8;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } trap_state_e;

  // ECALL cause depends on the privilege it was raised from (8, 9 or 11)
  function automatic logic [3:0] map_cause(input logic [1:0] excause,
                                           input logic [1:0] priv);
    logic [3:0] cause;
    case (excause)
      EXCAUSE_ECALL:         cause = MCAUSE_ECALL_BASE + {2'b00, priv};
      EXCAUSE_EBREAK:        cause = MCAUSE_BREAKPOINT;
      EXCAUSE_ILLEGAL_INSTR: cause = MCAUSE_ILLEGAL_INSTR;
      default:               cause = MCAUSE_MISALIGNED;
    endcase
    return cause;
  endfunction

endpackage

// File: rtl/cpu_trap_unit_if.sv
// cpu_trap_unit_if
//   Bundle between the pipeline (commit verdict, CSR access, fetch redirect)
//   and the trap sequencer.
//   master : pipeline/fetch side - drives commit, CSR request, redirect_ready
//   slave  : trap unit side      - drives CSR read data, redirect valid/pc
interface cpu_trap_unit_if #(
  parameter int XLEN = 32
);
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic            exception;
  logic [1:0]      excause;
  logic            mret;
  logic            csr_we;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_hit;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;

  modport master (
    output commit_valid, commit_pc, exception, excause, mret,
    output csr_we, csr_addr, csr_wdata, redirect_ready,
    input  csr_rdata, csr_hit, redirect_valid, redirect_pc
  );

  modport slave (
    input  commit_valid, commit_pc, exception, excause, mret,
    input  csr_we, csr_addr, csr_wdata, redirect_ready,
    output csr_rdata, csr_hit, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/cpu_trap_unit_csrs.sv
// cpu_trap_csrs
//   Trap CSR file: mstatus (MIE/MPIE/MPP), mtvec, mscratch, mepc, mcause.
//   Ports:
//     clk, rst_n              clock, async active-low reset
//     rd_addr -> rdata, hit   combinational read mux (0 / miss if unmapped)
//     wr_en, wr_addr, wr_data qualified CSR write (lowest priority)
//     trap_en, trap_pc_word,  trap entry update (pc given without bits [1:0])
//     trap_cause, trap_priv
//     mret_en                 mret stack pop on mstatus
//     mtvec, mepc, mpp        current values for the sequencer
module cpu_trap_csrs
  import cpu_trap_unit_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [11:0]     rd_addr,
  output logic [XLEN-1:0] rdata,
  output logic            hit,
  input  logic            wr_en,
  input  logic [11:0]     wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            trap_en,
  input  logic [XLEN-3:0] trap_pc_word,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [1:0]      trap_priv,
  input  logic            mret_en,
  output logic [XLEN-1:0] mtvec,
  output logic [XLEN-1:0] mepc,
  output logic [1:0]      mpp
);

  logic            mie_reg;
  logic            mpie_reg;
  logic [1:0]      mpp_reg;
  logic [XLEN-3:0] mtvec_reg;   // bits [1:0] are always zero, not stored
  logic [XLEN-1:0] mscratch_reg;
  logic [XLEN-3:0] mepc_reg;    // bits [1:0] are always zero, not stored
  logic [XLEN-1:0] mcause_reg;

  logic [1:0] wr_mpp;
  // Reserved MPP encoding 2 is legalised to U on write
  assign wr_mpp = (wr_data[MSTATUS_MPP_HI:MSTATUS_MPP_LO] == 2'b10)
                ? PRIV_U : wr_data[MSTATUS_MPP_HI:MSTATUS_MPP_LO];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_reg      <= 1'b0;
      mpie_reg     <= 1'b0;
      mpp_reg      <= PRIV_U;
      mtvec_reg    <= RESET_MTVEC[XLEN-1:2];
      mscratch_reg <= '0;
      mepc_reg     <= '0;
      mcause_reg   <= '0;
    end else if (trap_en) begin
      mepc_reg   <= trap_pc_word;
      mcause_reg <= trap_cause;
      mpie_reg   <= mie_reg;
      mie_reg    <= 1'b0;
      mpp_reg    <= trap_priv;
    end else if (mret_en) begin
      mie_reg  <= mpie_reg;
      mpie_reg <= 1'b1;
      mpp_reg  <= PRIV_U;
    end else if (wr_en) begin
      case (wr_addr)
        CSR_MSTATUS: begin
          mie_reg  <= wr_data[MSTATUS_MIE];
          mpie_reg <= wr_data[MSTATUS_MPIE];
          mpp_reg  <= wr_mpp;
        end
        CSR_MTVEC:    mtvec_reg    <= wr_data[XLEN-1:2];
        CSR_MSCRATCH: mscratch_reg <= wr_data;
        CSR_MEPC:     mepc_reg     <= wr_data[XLEN-1:2];
        CSR_MCAUSE:   mcause_reg   <= wr_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    hit   = 1'b1;
    case (rd_addr)
      CSR_MSTATUS: begin
        rdata[MSTATUS_MIE]                   = mie_reg;
        rdata[MSTATUS_MPIE]                  = mpie_reg;
        rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mpp_reg;
      end
      CSR_MTVEC:    rdata = {mtvec_reg, 2'b00};
      CSR_MSCRATCH: rdata = mscratch_reg;
      CSR_MEPC:     rdata = {mepc_reg, 2'b00};
      CSR_MCAUSE:   rdata = mcause_reg;
      default:      hit   = 1'b0;
    endcase
  end

  assign mtvec = {mtvec_reg, 2'b00};
  assign mepc  = {mepc_reg, 2'b00};
  assign mpp   = mpp_reg;

endmodule

// File: rtl/cpu_trap_unit.sv
// cpu_trap_unit
//   Machine-mode trap sequencer. Samples the commit verdict, performs trap
//   entry / mret, owns the privilege level and holds a redirect for fetch
//   until it is accepted.
//   Ports:
//     clk, rst_n  clock, async active-low reset
//     bus         cpu_trap_unit_if.slave (commit, CSR access, redirect)
//     priv        current privilege level (to exception logic)
//     busy        pipeline stall, equal to redirect_valid
module cpu_trap_unit
  import cpu_trap_unit_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cpu_trap_unit_if.slave        bus,
  output logic [1:0]            priv,
  output logic                  busy
);

  trap_state_e     state_reg, state_next;
  logic [1:0]      priv_reg, priv_next;
  logic [XLEN-1:0] redirect_pc_reg, redirect_pc_next;

  logic            idle;
  logic            trap_fire;
  logic            mret_fire;
  logic            wr_fire;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic [1:0]      mpp;
  logic [XLEN-1:0] trap_cause;
  logic            unused_pc_low;

  // Commit events only count in IDLE; exception beats mret beats CSR write
  assign idle      = (state_reg == ST_IDLE);
  assign trap_fire = idle && bus.commit_valid && bus.exception;
  assign mret_fire = idle && bus.commit_valid && !bus.exception && bus.mret;
  assign wr_fire   = idle && bus.commit_valid && bus.csr_we
                   && !bus.exception && !bus.mret;

  assign trap_cause    = XLEN'(map_cause(bus.excause, priv_reg));
  assign unused_pc_low = ^bus.commit_pc[1:0];

  cpu_trap_csrs #(
    .XLEN        (XLEN),
    .RESET_MTVEC (RESET_MTVEC)
  ) u_csrs (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_addr      (bus.csr_addr),
    .rdata        (bus.csr_rdata),
    .hit          (bus.csr_hit),
    .wr_en        (wr_fire),
    .wr_addr      (bus.csr_addr),
    .wr_data      (bus.csr_wdata),
    .trap_en      (trap_fire),
    .trap_pc_word (bus.commit_pc[XLEN-1:2]),
    .trap_cause   (trap_cause),
    .trap_priv    (priv_reg),
    .mret_en      (mret_fire),
    .mtvec        (mtvec),
    .mepc         (mepc),
    .mpp          (mpp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      priv_reg        <= PRIV_M;
      redirect_pc_reg <= '0;
    end else begin
      state_reg       <= state_next;
      priv_reg        <= priv_next;
      redirect_pc_reg <= redirect_pc_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    priv_next        = priv_reg;
    redirect_pc_next = redirect_pc_reg;
    case (state_reg)
      ST_IDLE: begin
        if (trap_fire) begin
          priv_next        = PRIV_M;
          redirect_pc_next = mtvec;
          state_next       = ST_REDIRECT;
        end else if (mret_fire) begin
          priv_next        = mpp;
          redirect_pc_next = mepc;
          state_next       = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        // Target stays frozen; leave only once fetch has taken it
        if (bus.redirect_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.redirect_valid = (state_reg == ST_REDIRECT);
  assign bus.redirect_pc    = redirect_pc_reg;
  assign busy               = (state_reg == ST_REDIRECT);
  assign priv               = priv_reg;

endmodule

// File: tb/tb_cpu_trap_unit.sv
module tb_cpu_trap_unit;
  import cpu_trap_unit_pkg::*;

  localparam int XLEN = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] priv;
  logic       busy;

  cpu_trap_unit_if #(.XLEN(XLEN)) bus ();

  cpu_trap_unit #(
    .XLEN        (XLEN),
    .RESET_MTVEC (32'h0000_0100)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .priv  (priv),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Architectural reference model
  int unsigned m_mie, m_mpie, m_mpp, m_priv;
  int unsigned m_mtvec, m_mscratch, m_mepc, m_mcause, m_rpc;
  bit          m_pend;

  function automatic int unsigned m_mstatus();
    return m_mie * 8 + m_mpie * 128 + m_mpp * 2048;
  endfunction

  function automatic int unsigned m_csr(input int unsigned addr);
    case (addr)
      32'h300: return m_mstatus();
      32'h305: return m_mtvec;
      32'h340: return m_mscratch;
      32'h341: return m_mepc;
      32'h342: return m_mcause;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_mpp = 0; m_priv = 3;
    m_mtvec = 32'h100; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
    m_rpc = 0; m_pend = 0;
  endtask

  task automatic model_commit(input int unsigned pc, input bit exc,
                              input int unsigned cause, input bit mr,
                              input bit we, input int unsigned addr,
                              input int unsigned wd);
    if (exc) begin
      m_mepc = pc - (pc % 4);
      if (cause == 0)      m_mcause = 8 + m_priv;
      else if (cause == 1) m_mcause = 3;
      else if (cause == 2) m_mcause = 2;
      else                 m_mcause = 4;
      m_mpie = m_mie; m_mie = 0; m_mpp = m_priv; m_priv = 3;
      m_rpc = m_mtvec; m_pend = 1;
    end else if (mr) begin
      m_priv = m_mpp; m_mie = m_mpie; m_mpie = 1; m_mpp = 0;
      m_rpc = m_mepc; m_pend = 1;
    end else if (we) begin
      case (addr)
        32'h300: begin
          m_mie  = (wd / 8) % 2;
          m_mpie = (wd / 128) % 2;
          m_mpp  = (wd / 2048) % 4;
          if (m_mpp == 2) m_mpp = 0;
        end
        32'h305: m_mtvec    = wd - (wd % 4);
        32'h340: m_mscratch = wd;
        32'h341: m_mepc     = wd - (wd % 4);
        32'h342: m_mcause   = wd;
        default: ;
      endcase
    end
  endtask

  task automatic clear_inputs();
    bus.commit_valid = 1'b0; bus.commit_pc = '0; bus.exception = 1'b0;
    bus.excause = 2'd0; bus.mret = 1'b0; bus.csr_we = 1'b0;
    bus.csr_wdata = '0;
  endtask

  // One committing instruction while IDLE; returns 1 time unit after the edge
  task automatic drive_commit(input logic [31:0] pc, input bit exc,
                              input logic [1:0] cause, input bit mr,
                              input bit we, input logic [11:0] addr,
                              input logic [31:0] wd);
    bus.commit_valid = 1'b1; bus.commit_pc = pc; bus.exception = exc;
    bus.excause = cause; bus.mret = mr; bus.csr_we = we;
    bus.csr_addr = addr; bus.csr_wdata = wd;
    model_commit(pc, exc, cause, mr, we, {20'd0, addr}, wd);
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic read_csr(input logic [11:0] addr, output logic [31:0] d);
    bus.csr_addr = addr;
    #1;
    d = bus.csr_rdata;
  endtask

  task automatic finish_redirect();
    bus.redirect_ready = 1'b1;
    @(posedge clk); #1;
    bus.redirect_ready = 1'b0;
    m_pend = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [11:0] addrs [5];
    addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342};
    clear_inputs();
    bus.csr_addr = 12'h300; bus.redirect_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (priv !== 2'd3) begin
      n_err++; $display("FAIL reset_priv got %0d want 3", priv);
    end
    n_cmp++;
    if (bus.redirect_valid !== 1'b0 || busy !== 1'b0 || bus.redirect_pc !== 32'h0) begin
      n_err++; $display("FAIL reset_redirect got v=%b busy=%b pc=%h want 0/0/0",
                        bus.redirect_valid, busy, bus.redirect_pc);
    end
    for (int i = 0; i < 5; i++) begin
      read_csr(addrs[i], d);
      n_cmp++;
      if (d !== ((i == 1) ? 32'h100 : 32'h0)) begin
        n_err++; $display("FAIL reset_csr_%h got %h want %h", addrs[i], d,
                          (i == 1) ? 32'h100 : 32'h0);
      end
    end
    $display("reset: checked priv, redirect and five CSRs");
  endtask

  task automatic test_csr_masking();
    logic [31:0] d;
    drive_commit(32'h0, 0, 2'd0, 0, 1, 12'h305, 32'h123);
    read_csr(12'h305, d);
    n_cmp++;
    if (d !== 32'h120) begin
      n_err++; $display("FAIL mtvec_mask got %h want 00000120", d);
    end
    drive_commit(32'h0, 0, 2'd0, 0, 1, 12'h300, 32'h1000);
    read_csr(12'h300, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL mstatus_mpp2 got %h want 00000000", d);
    end
    drive_commit(32'h0, 0, 2'd0, 0, 1, 12'h341, 32'hFFFF_FFFF);
    read_csr(12'h341, d);
    n_cmp++;
    if (d !== 32'hFFFF_FFFC) begin
      n_err++; $display("FAIL mepc_mask got %h want fffffffc", d);
    end
    drive_commit(32'h0, 0, 2'd0, 0, 1, 12'h342, 32'h8000_0005);
    read_csr(12'h342, d);
    n_cmp++;
    if (d !== 32'h8000_0005) begin
      n_err++; $display("FAIL mcause_full got %h want 80000005", d);
    end
    // Read data in the write cycle shows the old value
    bus.commit_valid = 1'b1; bus.csr_we = 1'b1; bus.csr_addr = 12'h340;
    bus.csr_wdata = 32'h1234_5678;
    #1;
    n_cmp++;
    if (bus.csr_rdata !== 32'h0) begin
      n_err++; $display("FAIL prewrite_read got %h want 00000000", bus.csr_rdata);
    end
    model_commit(0, 0, 0, 0, 1, 32'h340, 32'h1234_5678);
    @(posedge clk); #1;
    clear_inputs();
    read_csr(12'h340, d);
    n_cmp++;
    if (d !== 32'h1234_5678) begin
      n_err++; $display("FAIL mscratch_write got %h want 12345678", d);
    end
    read_csr(12'h344, d);
    n_cmp++;
    if (d !== 32'h0 || bus.csr_hit !== 1'b0) begin
      n_err++; $display("FAIL unmapped_csr got d=%h hit=%b want 0/0", d, bus.csr_hit);
    end
    drive_commit(32'h0, 0, 2'd0, 0, 1, 12'h300, 32'hFFFF_FFFF);
    read_csr(12'h300, d);
    n_cmp++;
    if (d !== 32'h1888 || bus.csr_hit !== 1'b1) begin
      n_err++; $display("FAIL mstatus_mask got %h hit=%b want 00001888/1", d, bus.csr_hit);
    end
    $display("csr_masking: mtvec/mstatus/mepc/mcause/mscratch write masks checked");
  endtask

  task automatic test_priority();
    logic [31:0] d;
    drive_commit(32'h500, 1, EXCAUSE_ILLEGAL_INSTR, 1, 1, 12'h340, 32'hDEAD);
    n_cmp++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h120 || priv !== 2'd3) begin
      n_err++; $display("FAIL prio_redirect got v=%b pc=%h priv=%0d want 1/00000120/3",
                        bus.redirect_valid, bus.redirect_pc, priv);
    end
    read_csr(12'h342, d);
    n_cmp++;
    if (d !== 32'h2) begin
      n_err++; $display("FAIL prio_mcause got %h want 00000002", d);
    end
    read_csr(12'h340, d);
    n_cmp++;
    if (d !== 32'h1234_5678) begin
      n_err++; $display("FAIL prio_mscratch got %h want 12345678", d);
    end
    read_csr(12'h300, d);
    n_cmp++;
    if (d[12:11] !== 2'd3 || d[3] !== 1'b0 || d[7] !== 1'b1) begin
      n_err++; $display("FAIL prio_mstatus got %h want 00001880", d);
    end
    finish_redirect();
    $display("priority: exception+mret+csr_we -> trap only");
  endtask

  task automatic test_ecall();
    logic [31:0] d;
    drive_commit(32'h0, 0, 2'd0, 0, 1, 12'h300, 32'h0);
    drive_commit(32'h0, 0, 2'd0, 0, 1, 12'h305, 32'h400);
    drive_commit(32'h0, 0, 2'd0, 0, 1, 12'h341, 32'h3000);
    drive_commit(32'h0, 0, 2'd0, 1, 0, 12'h300, 32'h0);
    n_cmp++;
    if (priv !== 2'd0 || bus.redirect_pc !== 32'h3000) begin
      n_err++; $display("FAIL ecall_setup got priv=%0d pc=%h want 0/00003000",
                        priv, bus.redirect_pc);
    end
    finish_redirect();
    drive_commit(32'h2004, 1, EXCAUSE_ECALL, 0, 0, 12'h300, 32'h0);
    n_cmp++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h400 || priv !== 2'd3) begin
      n_err++; $display("FAIL ecall_redirect got v=%b pc=%h priv=%0d want 1/00000400/3",
                        bus.redirect_valid, bus.redirect_pc, priv);
    end
    read_csr(12'h342, d);
    n_cmp++;
    if (d !== 32'h8) begin
      n_err++; $display("FAIL ecall_mcause got %h want 00000008", d);
    end
    read_csr(12'h341, d);
    n_cmp++;
    if (d !== 32'h2004) begin
      n_err++; $display("FAIL ecall_mepc got %h want 00002004", d);
    end
    read_csr(12'h300, d);
    n_cmp++;
    if (d[12:11] !== 2'd0) begin
      n_err++; $display("FAIL ecall_mpp got %0d want 0", d[12:11]);
    end
    $display("ecall: U-mode ECALL at 0x2004 trapped to 0x400");
  endtask

  task automatic test_redirect_hold();
    logic [31:0] d;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bus.redirect_valid !== 1'b1 || busy !== 1'b1 || bus.redirect_pc !== 32'h400) begin
        n_err++; $display("FAIL hold_cycle%0d got v=%b busy=%b pc=%h want 1/1/00000400",
                          i, bus.redirect_valid, busy, bus.redirect_pc);
      end
      if (i == 1) begin
        bus.commit_valid = 1'b1; bus.exception = 1'b1; bus.excause = 2'd1;
        bus.commit_pc = 32'h9990; bus.csr_we = 1'b1; bus.csr_addr = 12'h340;
        bus.csr_wdata = 32'hBAD;
      end
      @(posedge clk); #1;
      clear_inputs();
    end
    n_cmp++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h400) begin
      n_err++; $display("FAIL hold_cycle3 got v=%b pc=%h want 1/00000400",
                        bus.redirect_valid, bus.redirect_pc);
    end
    finish_redirect();
    n_cmp++;
    if (bus.redirect_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL hold_release got v=%b busy=%b want 0/0",
                        bus.redirect_valid, busy);
    end
    read_csr(12'h342, d);
    n_cmp++;
    if (d !== 32'h8) begin
      n_err++; $display("FAIL hold_ignored_commit mcause got %h want 00000008", d);
    end
    read_csr(12'h340, d);
    n_cmp++;
    if (d !== 32'h1234_5678) begin
      n_err++; $display("FAIL hold_ignored_write mscratch got %h want 12345678", d);
    end
    $display("redirect_hold: held 4 cycles, injected commit ignored");
  endtask

  task automatic test_mret();
    logic [31:0] d;
    drive_commit(32'h0, 0, 2'd0, 0, 1, 12'h341, 32'h2008);
    drive_commit(32'h0, 0, 2'd0, 0, 1, 12'h300, 32'h80);
    drive_commit(32'h0, 0, 2'd0, 1, 0, 12'h300, 32'h0);
    n_cmp++;
    if (priv !== 2'd0 || bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h2008) begin
      n_err++; $display("FAIL mret_redirect got priv=%0d v=%b pc=%h want 0/1/00002008",
                        priv, bus.redirect_valid, bus.redirect_pc);
    end
    read_csr(12'h300, d);
    n_cmp++;
    if (d !== 32'h88) begin
      n_err++; $display("FAIL mret_mstatus got %h want 00000088", d);
    end
    finish_redirect();
    $display("mret: returned to U at 0x2008");
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [11:0] addrs [6];
    logic [31:0] pc, wd;
    bit          exc, mr, we;
    logic [1:0]  cause;
    int          waits;
    addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h7C0};
    for (int it = 0; it < 200; it++) begin
      pc    = $urandom;
      wd    = $urandom;
      exc   = ($urandom_range(0, 3) == 0);
      mr    = ($urandom_range(0, 4) == 0);
      we    = $urandom_range(0, 1) == 1;
      cause = 2'($urandom_range(0, 3));
      drive_commit(pc, exc, cause, mr, we, addrs[$urandom_range(0, 5)], wd);
      n_cmp++;
      if (priv !== 2'(m_priv) || bus.redirect_valid !== m_pend ||
          (m_pend && bus.redirect_pc !== m_rpc)) begin
        n_err++; $display("FAIL rand%0d_ctrl got priv=%0d v=%b pc=%h want %0d/%b/%h",
                          it, priv, bus.redirect_valid, bus.redirect_pc,
                          m_priv, m_pend, m_rpc);
      end
      for (int i = 0; i < 5; i++) begin
        read_csr(addrs[i], d);
        n_cmp++;
        if (d !== m_csr({20'd0, addrs[i]})) begin
          n_err++; $display("FAIL rand%0d_csr_%h got %h want %h", it, addrs[i], d,
                            m_csr({20'd0, addrs[i]}));
        end
      end
      if (m_pend) begin
        @(posedge clk); #1;
        waits = $urandom_range(0, 2);
        for (int w = 0; w < waits; w++) begin
          bus.commit_valid = 1'b1; bus.exception = $urandom_range(0, 1) == 1;
          bus.mret = 1'b1; bus.csr_we = 1'b1; bus.csr_wdata = $urandom;
          bus.commit_pc = $urandom;
          @(posedge clk); #1;
          clear_inputs();
          n_cmp++;
          if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== m_rpc) begin
            n_err++; $display("FAIL rand%0d_hold got v=%b pc=%h want 1/%h",
                              it, bus.redirect_valid, bus.redirect_pc, m_rpc);
          end
        end
        finish_redirect();
        n_cmp++;
        if (bus.redirect_valid !== 1'b0) begin
          n_err++; $display("FAIL rand%0d_release got v=%b want 0", it, bus.redirect_valid);
        end
      end
      $display("rand%0d: exc=%b cause=%0d mret=%b we=%b priv=%0d", it, exc, cause, mr, we, m_priv);
    end
  endtask

  task automatic test_reset_mid_redirect();
    logic [31:0] d;
    drive_commit(32'h4444, 1, EXCAUSE_EBREAK, 0, 0, 12'h300, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (bus.redirect_valid !== 1'b0 || busy !== 1'b0 || bus.redirect_pc !== 32'h0 ||
        priv !== 2'd3) begin
      n_err++; $display("FAIL async_reset got v=%b busy=%b pc=%h priv=%0d want 0/0/0/3",
                        bus.redirect_valid, busy, bus.redirect_pc, priv);
    end
    read_csr(12'h342, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL async_reset_mcause got %h want 00000000", d);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.redirect_valid !== 1'b0) begin
      n_err++; $display("FAIL async_reset_after got v=%b want 0", bus.redirect_valid);
    end
    $display("reset_mid_redirect: pending redirect dropped");
  endtask

  initial begin
    test_reset();
    test_csr_masking();
    test_priority();
    test_ecall();
    test_redirect_hold();
    test_mret();
    test_random();
    test_reset_mid_redirect();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_trap_unit.md
# cpu_trap_unit

Machine-mode trap sequencer directly downstream of the CPU exception logic. It consumes the per-instruction `exception`/`excause` verdict at commit and owns the privilege register that feeds back to that logic. It holds the trap CSRs (mstatus, mtvec, mscratch, mepc, mcause), performs trap entry and `mret` return, and issues a held redirect to fetch through a valid/ready handshake, stalling the pipeline until fetch accepts.

## Interface
- `XLEN`, 32: datapath width.
- `RESET_MTVEC`, 32'h0000_0100: reset value of mtvec; bits [1:0] are ignored.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `commit_valid` in 1: an instruction is retiring this cycle.
- `commit_pc` in XLEN: PC of the retiring instruction.
- `exception` in 1: exception verdict for the retiring instruction.
- `excause` in 2: exception cause code.
- `mret` in 1: the retiring instruction is `mret`.
- `csr_we` in 1: CSR write request from the retiring instruction.
- `csr_addr` in 12: CSR address.
- `csr_wdata` in XLEN: CSR write data.
- `csr_rdata` out XLEN: combinational read data for `csr_addr`; 0 when the address is not held here.
- `csr_hit` out 1: `csr_addr` is one of the five CSRs held here.
- `priv` out 2: current privilege level, fed to the exception logic.
- `redirect_valid` out 1: a redirect is pending.
- `redirect_pc` out XLEN: redirect target.
- `redirect_ready` in 1: fetch accepts the redirect.
- `busy` out 1: pipeline stall; equals `redirect_valid`.

## Operation
- Privilege encoding: U=0, S=1, M=3.
- FSM state IDLE:
  - Events are sampled only when `commit_valid` is high. Priority is exception, then `mret`, then CSR write.
  - Trap entry:
    - mepc <= `commit_pc` with bits [1:0] cleared.
    - mcause <= mapped cause.
    - mstatus.MPIE <= MIE; MIE <= 0; MPP <= `priv`; `priv` <= M.
    - `redirect_pc` <= {mtvec[XLEN-1:2], 2'b00}.
    - Next state REDIRECT.
  - `mret`:
    - `priv` <= MPP; MIE <= MPIE; MPIE <= 1; MPP <= U.
    - `redirect_pc` <= mepc.
    - Next state REDIRECT.
  - CSR write: update the addressed register. A write is dropped when an exception or `mret` is present in the same cycle.
- FSM state REDIRECT:
  - `redirect_valid`=1; `redirect_pc` is held stable.
  - All commit inputs are ignored.
  - Returns to IDLE on the cycle after `redirect_valid && redirect_ready`.
- Cause mapping, with codes taken from the shared header:
  - EXCAUSE_ECALL (0) -> 8 + `priv`, giving 8, 9 or 11.
  - EXCAUSE_EBREAK (1) -> 3.
  - EXCAUSE_ILLEGAL_INSTR (2) -> 2.
  - EXCAUSE_MISALIGNED (3) -> 4.
  - mcause is zero-extended to XLEN; bit XLEN-1 is always 0 (no interrupts).
- CSR map:
  - mstatus 0x300: only MIE[3], MPIE[7] and MPP[12:11] are implemented; other bits read 0. A write of MPP=2 stores U.
  - mtvec 0x305: bits [1:0] read 0 (direct mode only).
  - mscratch 0x340: full width.
  - mepc 0x341: bits [1:0] read 0.
  - mcause 0x342: full width.
- `mret` legality (privilege M) is checked upstream; this block executes any `mret` it receives.

## Timing
- Reset values: `priv`=M, mstatus fields 0, mepc=0, mcause=0, mscratch=0, mtvec=RESET_MTVEC with bits [1:0] cleared, state IDLE, `redirect_valid`=0, `redirect_pc`=0.
- Trap and `mret` latency: all state updates land at the commit edge. `redirect_valid` rises in the next cycle.
- Redirect handshake:
  - `redirect_valid` stays high until sampled with `redirect_ready`.
  - Minimum REDIRECT dwell is one cycle.
  - `redirect_ready` is a don't-care in IDLE.
- `csr_rdata` is combinational and reflects the pre-write value in the cycle of a write.
- Exception arriving with `mret` asserted: trap entry only.
- Reset asserted mid-REDIRECT: outputs return to reset values immediately (asynchronous reset); no pending redirect survives.

## Structure
- Shared header/package holds:
  - EXCAUSE_* codes;
  - PRIV_U/S/M;
  - CSR address constants;
  - mstatus bit positions;
  - mcause values.
- One sub-module is natural: `cpu_trap_csrs`, the CSR register file with read mux and write masking. The FSM, cause mapping and redirect logic stay at top level.

## Test plan
- Reset, then read all five CSRs -> `priv`=3, mtvec=0x100, others 0, `redirect_valid`=0.
- `priv`=U, commit at pc 0x2004 with exception and excause=ECALL, mtvec=0x400 -> mcause=8, mepc=0x2004, MPP=0, `priv`=3, `redirect_pc`=0x400 asserted the next cycle.
- Redirect with `redirect_ready` low for 3 cycles -> `redirect_valid` and `redirect_pc` held for 4 cycles; a commit injected meanwhile has no effect; return to IDLE after acceptance.
- `mret` with mepc=0x2008, MPP=U, MPIE=1 -> `priv`=0, MIE=1, MPIE=1, MPP=0, `redirect_pc`=0x2008.
- Same-cycle exception (ILLEGAL_INSTR), `mret` and csr_we to mscratch=0xDEAD -> mcause=2, mscratch unchanged, MPP=3.
- csr_we mtvec=0x123 and mstatus=0xFFFF_FFFF -> mtvec reads 0x120; mstatus reads 0x1888.
